// File: rtl/sm_delay_if.sv
// Bus bundle for the sign-magnitude delay line: control strobes, sample in, delayed sample out.
interface sm_delay_if #(
  parameter int W  = 16,
  parameter int DW = 4
);
  logic          ce;
  logic          flush;
  logic [DW-1:0] delay_sel;
  logic [W-1:0]  val_in;
  logic          sign_in;
  logic          valid_in;
  logic [W-1:0]  val_out;
  logic          sign_out;
  logic          valid_out;
  logic          busy;

  modport master (
    output ce, flush, delay_sel, val_in, sign_in, valid_in,
    input  val_out, sign_out, valid_out, busy
  );

  modport slave (
    input  ce, flush, delay_sel, val_in, sign_in, valid_in,
    output val_out, sign_out, valid_out, busy
  );
endinterface

// File: rtl/sm_delay_line.sv
// Runtime-programmable delay line for sign-magnitude samples, counted in ce ticks,
// with flush, -0 normalisation and valid blanking while a new delay settles.
module sm_delay_line #(
  parameter int W         = 16,
  parameter int MAX_DEPTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  sm_delay_if.slave bus
);
  localparam int DW = $clog2(MAX_DEPTH + 1);

  typedef struct packed {
    logic         valid;
    logic         sign;
    logic [W-1:0] val;
  } stage_t;

  stage_t        st [MAX_DEPTH];
  stage_t        tap;
  logic [DW-1:0] del_q;
  logic [DW-1:0] hold_cnt;
  logic [DW-1:0] del_req;

  function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] d);
    if (d == '0)
      return DW'(1);
    if (d > DW'(MAX_DEPTH))
      return DW'(MAX_DEPTH);
    return d;
  endfunction

  assign del_req = clamp_delay(bus.delay_sel);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_DEPTH; i++)
        st[i] <= '0;
      del_q    <= DW'(1);
      hold_cnt <= '0;
    end else begin
      del_q <= del_req;
      if (bus.flush) begin
        for (int i = 0; i < MAX_DEPTH; i++)
          st[i] <= '0;
        hold_cnt <= '0;
      end else begin
        if (bus.ce) begin
          // a zero magnitude is always stored positive so -0 never escapes
          st[0] <= {bus.valid_in, bus.sign_in & (bus.val_in != '0), bus.val_in};
          for (int i = 1; i < MAX_DEPTH; i++)
            st[i] <= st[i-1];
        end
        if (del_req != del_q)
          hold_cnt <= del_req;
        else if (bus.ce && (hold_cnt != '0))
          hold_cnt <= hold_cnt - DW'(1);
      end
    end
  end

  // Output tap selected from registered stages only
  always_comb begin
    tap = '0;
    for (int i = 0; i < MAX_DEPTH; i++)
      if (del_q == DW'(i + 1))
        tap = st[i];
  end

  assign bus.busy      = (hold_cnt != '0);
  assign bus.val_out   = tap.val;
  assign bus.sign_out  = tap.sign;
  assign bus.valid_out = tap.valid & ~bus.busy;
endmodule

// File: tb/tb_sm_delay_line.sv
// Randomised bench for sm_delay_line: stimulus feeds a tick-indexed sample history model,
// expected outputs are queued and a separate monitor compares them every clock.
module tb_sm_delay_line;
  localparam int W         = 16;
  localparam int MAX_DEPTH = 8;
  localparam int DW        = $clog2(MAX_DEPTH + 1);

  typedef struct packed {
    logic         valid;
    logic         sign;
    logic [W-1:0] val;
  } sample_t;

  typedef struct packed {
    logic [W-1:0] val;
    logic         sign;
    logic         valid;
    logic         busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  sm_delay_if #(.W(W), .DW(DW)) bus ();

  sm_delay_line #(.W(W), .MAX_DEPTH(MAX_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference model state: every accepted sample is kept, indexed by its ce tick
  sample_t hist[$];
  int      ce_n       = 0;
  int      clear_mark = 0;
  int      del_m      = 1;
  int      hold_m     = 0;
  exp_t    expq[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int clamp_ref(input int d);
    if (d < 1)
      return 1;
    if (d > MAX_DEPTH)
      return MAX_DEPTH;
    return d;
  endfunction

  task automatic model_step(input logic r, input logic c, input logic f, input int d,
                            input logic [W-1:0] v, input logic s, input logic vl);
    int      req;
    int      t;
    sample_t smp;
    exp_t    e;
    req = clamp_ref(d);
    if (!r) begin
      del_m      = 1;
      hold_m     = 0;
      clear_mark = ce_n;
    end else begin
      if (f) begin
        hold_m     = 0;
        clear_mark = ce_n;
      end else begin
        if (req != del_m)
          hold_m = req;
        else if (c && hold_m > 0)
          hold_m = hold_m - 1;
        if (c) begin
          ce_n++;
          smp.valid = vl;
          smp.sign  = (v == 0) ? 1'b0 : s;
          smp.val   = v;
          hist.push_back(smp);
        end
      end
      del_m = req;
    end
    // the output is the sample accepted del_m ticks ago, unless cleared since
    t = ce_n - del_m + 1;
    if (t > clear_mark)
      smp = hist[t-1];
    else
      smp = '0;
    e.val   = smp.val;
    e.sign  = smp.sign;
    e.busy  = (hold_m != 0);
    e.valid = smp.valid & ~e.busy;
    expq.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic c, input logic f, input int d,
                     input logic [W-1:0] v, input logic s, input logic vl);
    @(negedge clk);
    rst_n         = r;
    bus.ce        = c;
    bus.flush     = f;
    bus.delay_sel = DW'(d);
    bus.val_in    = v;
    bus.sign_in   = s;
    bus.valid_in  = vl;
    model_step(r, c, f, d, v, s, vl);
  endtask

  // monitor: one expected entry per clock once the driver has started
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        n_checks++;
        if (bus.val_out !== e.val || bus.sign_out !== e.sign ||
            bus.valid_out !== e.valid || bus.busy !== e.busy) begin
          n_fail++;
          $display("FAIL out_check t=%0t: got val=%h sign=%b valid=%b busy=%b, want val=%h sign=%b valid=%b busy=%b",
                   $time, bus.val_out, bus.sign_out, bus.valid_out, bus.busy,
                   e.val, e.sign, e.valid, e.busy);
        end
      end
    end
  end

  initial begin
    int d_cur;
    rst_n         = 1'b0;
    bus.ce        = 1'b0;
    bus.flush     = 1'b0;
    bus.delay_sel = '0;
    bus.val_in    = '0;
    bus.sign_in   = 1'b0;
    bus.valid_in  = 1'b0;

    repeat (2) cyc(0, 1, 0, 1, 16'h0, 0, 0);

    // single-clock latency at delay 1
    cyc(1, 1, 0, 1, 16'h1234, 1, 1);
    cyc(1, 1, 0, 1, 16'h0000, 0, 0);
    cyc(1, 1, 0, 1, 16'h0000, 0, 0);

    // delay 5 with ce every third clock, ramp input
    for (int k = 1; k <= 20; k++)
      for (int p = 0; p < 3; p++)
        cyc(1, p == 0, 0, 5, W'(k), 0, 1);

    // negative-zero normalisation
    for (int k = 0; k < 12; k++)
      cyc(1, 1, 0, 2, (k % 2 == 0) ? 16'h0000 : 16'h0001, 1, 1);

    // retune 3 -> 6 during a stream, then out-of-range selects
    for (int k = 0; k < 10; k++) cyc(1, 1, 0, 3, W'(100 + k), k[0], 1);
    for (int k = 0; k < 12; k++) cyc(1, 1, 0, 6, W'(200 + k), k[0], 1);
    for (int k = 0; k < 6; k++)  cyc(1, 1, 0, 0, W'(300 + k), 0, 1);
    for (int k = 0; k < 12; k++) cyc(1, 1, 0, 15, W'(400 + k), 1, 1);

    // flush a full pipeline, then refill
    for (int k = 0; k < 10; k++) cyc(1, 1, 0, 8, W'(500 + k), 0, 1);
    cyc(1, 1, 1, 8, 16'hBEEF, 1, 1);
    for (int k = 0; k < 12; k++) cyc(1, 1, 0, 8, W'(600 + k), 0, 1);

    // reset mid-stream at delay 4
    for (int k = 0; k < 8; k++) cyc(1, 1, 0, 4, W'(700 + k), 1, 1);
    cyc(0, 1, 0, 4, 16'h7777, 1, 1);
    for (int k = 0; k < 10; k++) cyc(1, 1, 0, 4, W'(800 + k), 0, 1);

    // randomised soak
    d_cur = 4;
    for (int n = 0; n < 2000; n++) begin
      logic [W-1:0] v;
      if ($urandom_range(0, 24) == 0)
        d_cur = $urandom_range(0, 15);
      v = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 59) == 0), d_cur, v, 1'($urandom), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    if (expq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
